// File: rtl/spi_frame_shifter.sv
// SPI mode-0 frame shifter driven by conditioned SCLK/CS/MOSI.
// Receives MSB-first words, drives a registered MISO, flags aborted frames.
//
// Ports:
//   clk, reset           system clock, async active-high reset
//   cs_cond              conditioned chip select (active low)
//   sclk_posedge/negedge one-cycle SCLK edge pulses
//   mosi_cond            conditioned MOSI level
//   tx_data, tx_load     word to transmit, load strobe (IDLE only)
//   rx_data, rx_valid    last received word, one-cycle update pulse
//   miso                 registered serial output
//   busy                 high while a frame is active
//   frame_abort          one-cycle pulse: CS released mid-word
//   bit_count            bits captured in the current word
module spi_frame_shifter #(
  parameter int WIDTH = 8,
  localparam int CNTW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs_cond,
  input  logic             sclk_posedge,
  input  logic             sclk_negedge,
  input  logic             mosi_cond,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             miso,
  output logic             busy,
  output logic             frame_abort,
  output logic [CNTW-1:0]  bit_count
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  logic [0:0]       state;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] tx_shift;

  assign busy = (state == SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rx_data     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      rx_valid    <= 1'b0;
      miso        <= 1'b0;
      frame_abort <= 1'b0;
      bit_count   <= '0;
    end else begin
      rx_valid    <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (tx_load)
            tx_shift <= tx_data;
          if (!cs_cond) begin
            state     <= SHIFT;
            bit_count <= '0;
            // A same-cycle load must present its MSB immediately.
            miso      <= tx_load ? tx_data[WIDTH-1]
                                 : tx_shift[WIDTH-1];
          end
        end
        SHIFT: begin
          // CS release wins over any edge pulse in the same cycle.
          if (cs_cond) begin
            state       <= IDLE;
            miso        <= 1'b0;
            frame_abort <= (bit_count != '0);
            bit_count   <= '0;
          end else if (sclk_posedge) begin
            rx_shift <= {rx_shift[WIDTH-2:0], mosi_cond};
            if (bit_count == LAST) begin
              rx_data   <= {rx_shift[WIDTH-2:0], mosi_cond};
              rx_valid  <= 1'b1;
              bit_count <= '0;
            end else begin
              bit_count <= bit_count + CNTW'(1);
            end
          end else if (sclk_negedge) begin
            // Count of zero on a falling edge means a word just
            // finished: start the next word from tx_data.
            if (bit_count != '0) begin
              tx_shift <= tx_shift << 1;
              miso     <= tx_shift[WIDTH-2];
            end else begin
              tx_shift <= tx_data;
              miso     <= tx_data[WIDTH-1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_shifter.sv
// Bench for spi_frame_shifter: directed SPI frames against a
// queue-based word model, checked every cycle plus literal checks.
module tb_spi_frame_shifter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_cond;
  logic       sclk_posedge;
  logic       sclk_negedge;
  logic       mosi_cond;
  logic [7:0] tx_data;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       miso;
  logic       busy;
  logic       frame_abort;
  logic [2:0] bit_count;

  spi_frame_shifter #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .cs_cond     (cs_cond),
    .sclk_posedge(sclk_posedge),
    .sclk_negedge(sclk_negedge),
    .mosi_cond   (mosi_cond),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .miso        (miso),
    .busy        (busy),
    .frame_abort (frame_abort),
    .bit_count   (bit_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Word-level model: a frame collects MOSI bits in a queue; a full
  // queue becomes a received word. MISO shows bit (7 - bits seen) of
  // the word being sent.
  bit         m_busy;
  bit         m_valid;
  bit         m_abort;
  bit         m_miso;
  logic [7:0] m_rx;
  logic [7:0] m_tx;
  logic [7:0] m_txw;
  bit         q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy  = 0;
      m_valid = 0;
      m_abort = 0;
      m_miso  = 0;
      m_rx    = '0;
      m_tx    = '0;
      m_txw   = '0;
      q.delete();
    end else begin
      m_valid = 0;
      m_abort = 0;
      if (!m_busy) begin
        m_miso = 0;
        if (!cs_cond) begin
          m_txw  = tx_load ? tx_data : m_tx;
          m_busy = 1;
          q.delete();
          m_miso = m_txw[7];
        end
        if (tx_load) m_tx = tx_data;
      end else if (cs_cond) begin
        m_abort = (q.size() != 0);
        m_busy  = 0;
        m_miso  = 0;
        q.delete();
      end else if (sclk_posedge) begin
        q.push_back(mosi_cond);
        if (q.size() == 8) begin
          for (int i = 0; i < 8; i++)
            m_rx[7-i] = q[i];
          m_valid = 1;
          q.delete();
        end
      end else if (sclk_negedge) begin
        if (q.size() == 0) begin
          m_txw  = tx_data;
          m_miso = m_txw[7];
        end else begin
          m_miso = m_txw[7-q.size()];
        end
        m_tx = m_txw << q.size();
      end
    end
  end

  int         nvalid;
  int         nabort;
  logic [7:0] wq[$];

  always @(negedge clk) begin
    #2;
    chk("rx_data", 32'(rx_data), 32'(m_rx));
    chk("rx_valid", 32'(rx_valid), 32'(m_valid));
    chk("miso", 32'(miso), 32'(m_miso));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_abort", 32'(frame_abort), 32'(m_abort));
    chk("bit_count", 32'(bit_count), 32'(q.size()));
    if (rx_valid === 1'b1) begin
      nvalid++;
      wq.push_back(rx_data);
    end
    if (frame_abort === 1'b1) nabort++;
  end

  logic [7:0] cap;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_cycle(input logic b);
    mosi_cond = b;
    tick(3);
    cap = {cap[6:0], miso};
    sclk_posedge = 1'b1;
    tick(1);
    sclk_posedge = 1'b0;
    tick(3);
    sclk_negedge = 1'b1;
    tick(1);
    sclk_negedge = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--)
      sclk_cycle(w[i]);
  endtask

  task automatic load_and_start(input logic [7:0] w);
    tx_data = w;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    cs_cond = 1'b0;
    tick(2);
  endtask

  logic [7:0] w;

  initial begin
    reset        = 1'b1;
    cs_cond      = 1'b1;
    sclk_posedge = 1'b0;
    sclk_negedge = 1'b0;
    mosi_cond    = 1'b0;
    tx_data      = '0;
    tx_load      = 1'b0;
    cap          = '0;
    nvalid       = 0;
    nabort       = 0;
    tick(3);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_bit_count", 32'(bit_count), 32'h0);
    reset = 1'b0;
    tick(2);

    // Single word: send A5, receive 3C.
    nvalid = 0;
    load_and_start(8'hA5);
    send_word(8'h3C);
    tick(2);
    chk("t2_rx_data", 32'(rx_data), 32'h3C);
    chk("t2_valid_cnt", 32'(nvalid), 32'd1);
    chk("t2_miso_seq", 32'(cap), 32'hA5);
    cs_cond = 1'b1;
    tick(3);

    // Two-word frame.
    nvalid = 0;
    wq.delete();
    load_and_start(8'h5A);
    send_word(8'h81);
    chk("t3_cnt0_a", 32'(bit_count), 32'h0);
    send_word(8'h7E);
    chk("t3_cnt0_b", 32'(bit_count), 32'h0);
    tick(2);
    chk("t3_valid_cnt", 32'(nvalid), 32'd2);
    chk("t3_nwords", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      chk("t3_word0", 32'(wq[0]), 32'h81);
      chk("t3_word1", 32'(wq[1]), 32'h7E);
    end
    chk("t3_miso_seq2", 32'(cap), 32'h5A);
    cs_cond = 1'b1;
    tick(3);

    // Abort after three bits.
    nvalid = 0;
    nabort = 0;
    load_and_start(8'hF0);
    sclk_cycle(1'b1);
    sclk_cycle(1'b0);
    sclk_cycle(1'b1);
    cs_cond = 1'b1;
    tick(3);
    chk("t4_abort_cnt", 32'(nabort), 32'd1);
    chk("t4_valid_cnt", 32'(nvalid), 32'd0);
    chk("t4_rx_hold", 32'(rx_data), 32'h7E);
    chk("t4_busy", 32'(busy), 32'h0);
    chk("t4_miso", 32'(miso), 32'h0);

    // Reset at bit 5 of a frame sending FF.
    nvalid = 0;
    nabort = 0;
    load_and_start(8'hFF);
    for (int i = 0; i < 5; i++)
      sclk_cycle(1'(i));
    chk("t1_pre_busy", 32'(busy), 32'h1);
    chk("t1_pre_cnt", 32'(bit_count), 32'd5);
    #1;
    reset   = 1'b1;
    cs_cond = 1'b1;
    #1;
    chk("t1_rx_data", 32'(rx_data), 32'h0);
    chk("t1_miso", 32'(miso), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_cnt", 32'(bit_count), 32'h0);
    chk("t1_valid", 32'(rx_valid), 32'h0);
    chk("t1_abort", 32'(frame_abort), 32'h0);
    tick(2);
    reset = 1'b0;
    tick(3);
    chk("t1_valid_cnt", 32'(nvalid), 32'd0);
    chk("t1_abort_cnt", 32'(nabort), 32'd0);

    // Edge pulses with CS high are ignored.
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      mosi_cond    = 1'b1;
      sclk_posedge = 1'b1;
      tick(1);
      sclk_posedge = 1'b0;
      sclk_negedge = 1'b1;
      tick(1);
      sclk_negedge = 1'b0;
    end
    tick(2);
    chk("t5_valid_cnt", 32'(nvalid), 32'd0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_cnt", 32'(bit_count), 32'h0);

    // CS release coincident with the 8th posedge.
    load_and_start(8'h3C);
    send_word(8'h96);
    tick(2);
    chk("t6_first_word", 32'(rx_data), 32'h96);
    nvalid = 0;
    nabort = 0;
    w = 8'h55;
    for (int i = 7; i >= 1; i--)
      sclk_cycle(w[i]);
    mosi_cond = w[0];
    tick(3);
    cs_cond      = 1'b1;
    sclk_posedge = 1'b1;
    tick(1);
    sclk_posedge = 1'b0;
    tick(3);
    chk("t6_abort_cnt", 32'(nabort), 32'd1);
    chk("t6_valid_cnt", 32'(nvalid), 32'd0);
    chk("t6_rx_hold", 32'(rx_data), 32'h96);
    chk("t6_busy", 32'(busy), 32'h0);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
